alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Command-driven controller that sequences the ALU datapath (convolution, pool, reverse pool, subtraction, dot product) over a run of 8x8 tiles. For each tile it requests operand loads from the read buffers, and the mask for convolution. It then holds the ALU operation select for a fixed compute latency and hands the result to write-back. It sits between the top-level command source and the ALU/READ_BUFFER/MASK_BUFFER/WRITE_BACK blocks.

## Interface
- ADDR_W, 24: DDR3 block address width
- CNT_W, 16: tile-count width
- SRC_STRIDE, 64: per-tile source address increment
- DST_STRIDE, 64: per-tile destination address increment
- ALU_LAT, 2: ALU compute cycles per tile (>=1)
- iCLK  in  1  clock; all logic on rising edge
- iRST  in  1  reset; asynchronous, active-high
- iCMD_VALID  in  1  command valid
- oCMD_READY  out  1  command ready; high only in IDLE
- iCMD_OP  in  3  opcode: 1 conv, 2 pool, 3 rev pool, 4 subtraction, 5 dot product; 0/6/7 illegal
- iCMD_SRC1, iCMD_SRC2, iCMD_DST  in  ADDR_W each  first-tile addresses
- iCMD_COUNT  in  CNT_W  number of tiles
- oRD_REQ  out  1  one-cycle operand load request
- oRD_ADDR1, oRD_ADDR2  out  ADDR_W each  current source addresses
- oRD_SRC2_EN  out  1  second operand needed (ops 4, 5)
- iRD_DONE  in  1  operand load complete (pulse)
- oMASK_REQ  out  1  one-cycle mask load request (conv, first tile only)
- iMASK_DONE  in  1  mask load complete (pulse)
- oALU_OP  out  3  latched opcode to ALU
- oALU_EN  out  1  ALU compute window
- oWB_REQ  out  1  one-cycle write-back request
- oWB_ADDR  out  ADDR_W  current destination address
- iWB_DONE  in  1  write-back complete (pulse)
- oBUSY  out  1  high in every state except IDLE
- oDONE  out  1  one-cycle command-complete pulse
- oERR  out  1  one-cycle illegal-opcode pulse

## Operation
- Reset values: all outputs 0, except oCMD_READY = 1; state IDLE.
- All outputs are registered (Moore).
- **IDLE:** accept when iCMD_VALID && oCMD_READY. Latch op, addresses and count.
  - oALU_OP takes the new op and holds it until the next accept.
  - Illegal op goes to ERR.
  - Count 0 goes to DONE.
  - Otherwise go to LOAD.
- **LOAD:**
  - First cycle: oRD_REQ = 1. If op = 1 and this is the first tile, oMASK_REQ = 1 in the same cycle.
  - Done inputs are ignored in the request cycle and sampled from the next cycle on.
  - iRD_DONE and iMASK_DONE set sticky flags. They may arrive in any order or in the same cycle.
  - Exit to COMPUTE in the cycle after all required flags are set. The flags clear on exit.
- **COMPUTE:** oALU_EN = 1 for exactly ALU_LAT cycles, counted by an internal counter. Then go to WRITE.
- **WRITE:**
  - First cycle: oWB_REQ = 1.
  - iWB_DONE is sampled from the next cycle on.
  - On iWB_DONE: remaining count decrements; SRC1, SRC2 advance by SRC_STRIDE and DST by DST_STRIDE.
  - If remaining was 1, go to DONE; otherwise go to LOAD.
- **DONE:** oDONE = 1 for one cycle, then IDLE.
- **ERR:** oERR = 1 for one cycle, then IDLE. No requests are issued.
- Address arithmetic is unsigned modulo 2^ADDR_W; wrap-around is silent.
- oRD_ADDR1/2 and oWB_ADDR always show the current tile's addresses.
- Unexpected done pulses are ignored and leave no residual state: iRD_DONE/iMASK_DONE outside LOAD, and iWB_DONE outside WRITE.
- Commands presented while busy are not accepted; the source must hold iCMD_VALID.
- iRST mid-operation aborts immediately to reset values. The in-flight command is lost and no oDONE is generated.

## Timing
- Accept on edge 0; LOAD is active in cycle 1.
- With done pulses arriving one cycle after their requests, each tile takes 4 + ALU_LAT cycles:
  - 2 in LOAD,
  - ALU_LAT in COMPUTE,
  - 2 in WRITE.
- Count N: oDONE in cycle 1 + N·(4 + ALU_LAT); oCMD_READY high again the following cycle.
- Count 0: oDONE in cycle 1. Illegal op: oERR in cycle 1.
- Each extra cycle of done latency adds exactly one cycle.
- oBUSY rises the cycle after accept and falls together with oCMD_READY rising.

## Test plan
- Pool, count 1, ALU_LAT = 2, SRC1 = 0x100, DST = 0x200, done pulses immediate:
  - oRD_REQ in cycle 1 with oRD_SRC2_EN = 0 and oMASK_REQ = 0.
  - oALU_EN in cycles 3–4, oALU_OP = 2.
  - oWB_REQ in cycle 5 with oWB_ADDR = 0x200.
  - oDONE in cycle 7.
- Conv, count 3:
  - oMASK_REQ only on tile 0.
  - iMASK_DONE arrives 3 cycles after iRD_DONE; LOAD waits for it.
  - oRD_ADDR1 sequence 0x100, 0x140, 0x180.
  - oDONE exactly once.
- Subtraction, count 2, SRC1 = 0xFFFFC0:
  - oRD_SRC2_EN = 1.
  - Second tile oRD_ADDR1 = 0x000000 (wrap).
  - iRD_DONE in the request cycle is ignored and delays the exit.
- Opcode 6 → oERR in cycle 1, no request pulses, oCMD_READY back in cycle 2.
- Count 0 → oDONE in cycle 1, no requests.
- iRST during COMPUTE of a dot-product tile → all outputs at reset values immediately, no oDONE. A new pool command is then accepted and completes normally.
- Back-to-back commands with iCMD_VALID held high → second accept in the cycle oCMD_READY rises; oALU_OP changes only at that accept.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the tiled ALU datapath.
// Handles load, compute and write-back steps per 8x8 tile; all outputs are registered.
module alu_op_sequencer #(
  parameter int ADDR_W     = 24,
  parameter int CNT_W      = 16,
  parameter int SRC_STRIDE = 64,
  parameter int DST_STRIDE = 64,
  parameter int ALU_LAT    = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [2:0]        iCMD_OP,
  input  logic [ADDR_W-1:0] iCMD_SRC1,
  input  logic [ADDR_W-1:0] iCMD_SRC2,
  input  logic [ADDR_W-1:0] iCMD_DST,
  input  logic [CNT_W-1:0]  iCMD_COUNT,
  output logic              oRD_REQ,
  output logic [ADDR_W-1:0] oRD_ADDR1,
  output logic [ADDR_W-1:0] oRD_ADDR2,
  output logic              oRD_SRC2_EN,
  input  logic              iRD_DONE,
  output logic              oMASK_REQ,
  input  logic              iMASK_DONE,
  output logic [2:0]        oALU_OP,
  output logic              oALU_EN,
  output logic              oWB_REQ,
  output logic [ADDR_W-1:0] oWB_ADDR,
  input  logic              iWB_DONE,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic [2:0]        oDBG_STATE
);

  // Command handshake: a command transfers on a rising edge where
  // iCMD_VALID && oCMD_READY; the source holds iCMD_VALID and the fields until then.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [LAT_W-1:0]   lat_cnt;
  logic               need_mask;
  logic               rd_flag;
  logic               mask_flag;
  logic               rd_ok;
  logic               mask_ok;
  logic               op_illegal;

  assign oDBG_STATE = state;
  assign op_illegal = (iCMD_OP == 3'd0) || (iCMD_OP > 3'd5);

  // Sticky flags OR'd with this cycle's pulse so LOAD exits on the edge the last one lands.
  assign rd_ok   = rd_flag | iRD_DONE;
  assign mask_ok = !need_mask | mask_flag | iMASK_DONE;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= S_IDLE;
      remaining   <= '0;
      lat_cnt     <= '0;
      need_mask   <= 1'b0;
      rd_flag     <= 1'b0;
      mask_flag   <= 1'b0;
      oCMD_READY  <= 1'b1;
      oRD_REQ     <= 1'b0;
      oRD_ADDR1   <= '0;
      oRD_ADDR2   <= '0;
      oRD_SRC2_EN <= 1'b0;
      oMASK_REQ   <= 1'b0;
      oALU_OP     <= '0;
      oALU_EN     <= 1'b0;
      oWB_REQ     <= 1'b0;
      oWB_ADDR    <= '0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      oRD_REQ   <= 1'b0;
      oMASK_REQ <= 1'b0;
      oWB_REQ   <= 1'b0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iCMD_VALID && oCMD_READY) begin
            oALU_OP    <= iCMD_OP;
            oRD_ADDR1  <= iCMD_SRC1;
            oRD_ADDR2  <= iCMD_SRC2;
            oWB_ADDR   <= iCMD_DST;
            remaining  <= iCMD_COUNT;
            oCMD_READY <= 1'b0;
            oBUSY      <= 1'b1;
            if (op_illegal) begin
              state <= S_ERR;
              oERR  <= 1'b1;
            end else if (iCMD_COUNT == '0) begin
              state <= S_DONE;
              oDONE <= 1'b1;
            end else begin
              state       <= S_LOAD;
              oRD_REQ     <= 1'b1;
              need_mask   <= (iCMD_OP == 3'd1);
              oMASK_REQ   <= (iCMD_OP == 3'd1);
              oRD_SRC2_EN <= (iCMD_OP == 3'd4) || (iCMD_OP == 3'd5);
            end
          end
        end
        S_LOAD: begin
          // The request cycle itself ignores done pulses.
          if (!oRD_REQ) begin
            if (rd_ok && mask_ok) begin
              state     <= S_COMPUTE;
              oALU_EN   <= 1'b1;
              lat_cnt   <= LAT_W'(ALU_LAT - 1);
              rd_flag   <= 1'b0;
              mask_flag <= 1'b0;
              need_mask <= 1'b0;
            end else begin
              if (iRD_DONE)   rd_flag   <= 1'b1;
              if (iMASK_DONE) mask_flag <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (lat_cnt == '0) begin
            state   <= S_WRITE;
            oALU_EN <= 1'b0;
            oWB_REQ <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          if (!oWB_REQ && iWB_DONE) begin
            remaining <= remaining - 1'b1;
            oRD_ADDR1 <= oRD_ADDR1 + ADDR_W'(SRC_STRIDE);
            oRD_ADDR2 <= oRD_ADDR2 + ADDR_W'(SRC_STRIDE);
            oWB_ADDR  <= oWB_ADDR + ADDR_W'(DST_STRIDE);
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
              oDONE <= 1'b1;
            end else begin
              state   <= S_LOAD;
              oRD_REQ <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          state       <= S_IDLE;
          oCMD_READY  <= 1'b1;
          oBUSY       <= 1'b0;
          oRD_SRC2_EN <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
